// File: rtl/sweep_if.sv
// rtl/sweep_if.sv - sweep scheduler control, FFT result and RAM write bundle
interface sweep_if #(
  parameter int ADDR_W = 12,
  parameter int FREQ_W = 16
);
  logic              start;
  logic              abort;
  logic              source_valid;
  logic [15:0]       fft_index;
  logic [15:0]       fft_real;
  logic [15:0]       fft_imag;
  logic [FREQ_W-1:0] freq_word;
  logic              next_freq;
  logic              fft_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_real;
  logic [15:0]       wr_imag;
  logic              busy;
  logic              sweep_done;
  logic              err;

  modport master (
    input  start, abort, source_valid, fft_index, fft_real, fft_imag,
    output freq_word, next_freq, fft_valid, wr_en, wr_addr, wr_real, wr_imag,
           busy, sweep_done, err
  );

  modport slave (
    output start, abort, source_valid, fft_index, fft_real, fft_imag,
    input  freq_word, next_freq, fft_valid, wr_en, wr_addr, wr_real, wr_imag,
           busy, sweep_done, err
  );
endinterface

// File: rtl/sweep_sched.sv
// rtl/sweep_sched.sv - frequency-sweep sequencer: settle, arm FFT, capture one bin, write RAM
module sweep_sched #(
  parameter int NUM_STEPS   = 2800,
  parameter int ADDR_W      = 12,
  parameter int FREQ_W      = 16,
  parameter int FREQ_START  = 1,
  parameter int FREQ_INC    = 1,
  parameter int BIN_START   = 1,
  parameter int BIN_INC     = 1,
  parameter int SETTLE_CYC  = 4096,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic     clk_1_6384m,
  input  logic     rst_n,
  sweep_if.master  bus_io
);
  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       target_q, target_d;
  logic [15:0]       cap_re_q, cap_re_d, cap_im_q, cap_im_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              next_freq_q, next_freq_d;
  logic              fft_valid_q, fft_valid_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [15:0]       wr_re_q, wr_re_d, wr_im_q, wr_im_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    cap_re_d    = cap_re_q;
    cap_im_d    = cap_im_q;
    freq_d      = freq_q;
    next_freq_d = 1'b0;
    fft_valid_d = fft_valid_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_re_d     = wr_re_q;
    wr_im_d     = wr_im_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    // abort wins over everything, including a start or a bin match in the same cycle
    if (bus_io.abort) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      fft_valid_d = 1'b0;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus_io.start) begin
          step_d      = '0;
          freq_d      = FREQ_W'(FREQ_START);
          next_freq_d = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          fft_valid_d = 1'b0;
          cnt_d       = CNT_W'(1);
          state_d     = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == CNT_W'(SETTLE_CYC)) state_d = S_ARM;
          else                             cnt_d   = cnt_q + CNT_W'(1);
        end
        S_ARM: begin
          fft_valid_d = 1'b1;
          target_d    = 16'(BIN_START) + 16'(BIN_INC) * 16'(step_q);
          cnt_d       = CNT_W'(1);
          state_d     = S_CAPTURE;
        end
        S_CAPTURE: begin
          if (bus_io.source_valid && bus_io.fft_index == target_q) begin
            cap_re_d = bus_io.fft_real;
            cap_im_d = bus_io.fft_imag;
            state_d  = S_WRITE;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
            cap_re_d = '0;
            cap_im_d = '0;
            err_d    = 1'b1;
            state_d  = S_WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Write strobe and the next frequency word appear together on the cycle after WRITE
        S_WRITE: begin
          wr_en_d     = 1'b1;
          wr_addr_d   = step_q;
          wr_re_d     = cap_re_q;
          wr_im_d     = cap_im_q;
          fft_valid_d = 1'b0;
          if (step_q == ADDR_W'(NUM_STEPS - 1)) begin
            state_d = S_DONE;
          end else begin
            step_d      = step_q + ADDR_W'(1);
            freq_d      = freq_q + FREQ_W'(FREQ_INC);
            next_freq_d = 1'b1;
            cnt_d       = CNT_W'(1);
            state_d     = S_SETTLE;
          end
        end
        S_DONE: begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1_6384m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      cnt_q       <= '0;
      target_q    <= '0;
      cap_re_q    <= '0;
      cap_im_q    <= '0;
      freq_q      <= '0;
      next_freq_q <= 1'b0;
      fft_valid_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_re_q     <= '0;
      wr_im_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      cap_re_q    <= cap_re_d;
      cap_im_q    <= cap_im_d;
      freq_q      <= freq_d;
      next_freq_q <= next_freq_d;
      fft_valid_q <= fft_valid_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_re_q     <= wr_re_d;
      wr_im_q     <= wr_im_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus_io.freq_word  = freq_q;
  assign bus_io.next_freq  = next_freq_q;
  assign bus_io.fft_valid  = fft_valid_q;
  assign bus_io.wr_en      = wr_en_q;
  assign bus_io.wr_addr    = wr_addr_q;
  assign bus_io.wr_real    = wr_re_q;
  assign bus_io.wr_imag    = wr_im_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.sweep_done = done_q;
  assign bus_io.err        = err_q;
endmodule

// File: tb/tb_sweep_sched.sv
// tb/tb_sweep_sched.sv - directed scoreboard bench for sweep_sched with a cycling FFT bin model
module tb_sweep_sched;
  localparam int NSTEP = 4;

  logic clk;
  logic rst_n;
  logic start_r, abort_r, model_abort, sv_r;
  logic [15:0] idx_r, re_r, im_r;
  logic [15:0] skip_bin, abort_bin;
  int   n_vec, n_err, wr_cnt, nf_cnt;

  typedef struct {
    logic [11:0] addr;
    logic [15:0] re;
    logic [15:0] im;
  } wr_t;
  wr_t         exp_q[$];
  logic [15:0] freq_exp_q[$];

  sweep_if #(.ADDR_W(12), .FREQ_W(16)) bus ();

  assign bus.start        = start_r;
  assign bus.abort        = abort_r | model_abort;
  assign bus.source_valid = sv_r;
  assign bus.fft_index    = idx_r;
  assign bus.fft_real     = re_r;
  assign bus.fft_imag     = im_r;

  sweep_sched #(
    .NUM_STEPS(NSTEP), .ADDR_W(12), .FREQ_W(16), .FREQ_START(10), .FREQ_INC(5),
    .BIN_START(3), .BIN_INC(2), .SETTLE_CYC(8), .TIMEOUT_CYC(32)
  ) dut (
    .clk_1_6384m(clk),
    .rst_n(rst_n),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_freq"}, 32'(bus.freq_word), 0);
    check({tag, "_ctl"}, {26'd0, bus.next_freq, bus.fft_valid, bus.wr_en, bus.busy,
                          bus.sweep_done, bus.err}, 0);
    check({tag, "_wr"}, {4'd0, bus.wr_addr, bus.wr_real}, 0);
    check({tag, "_imag"}, 32'(bus.wr_imag), 0);
  endtask

  // FFT model: while enabled, emits bins 0..15 cyclically with real=bin, imag=-bin
  initial begin
    int bin_ctr;
    bin_ctr = 0;
    sv_r = 0; idx_r = '0; re_r = '0; im_r = '0; model_abort = 0;
    forever begin
      @(negedge clk);
      model_abort = 0;
      if (bus.fft_valid) begin
        idx_r   = 16'(bin_ctr);
        re_r    = 16'(bin_ctr);
        im_r    = 16'(-bin_ctr);
        sv_r    = (idx_r != skip_bin);
        bin_ctr = (bin_ctr + 1) % 16;
        if (sv_r && idx_r == abort_bin) model_abort = 1;
      end else begin
        bin_ctr = 0;
        sv_r    = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 0, 1);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          check("wr_real", 32'(bus.wr_real), 32'(e.re));
          check("wr_imag", 32'(bus.wr_imag), 32'(e.im));
        end
      end
      if (bus.next_freq) begin
        nf_cnt++;
        if (freq_exp_q.size() == 0) check("nf_unexpected", 0, 1);
        else check("freq_word", 32'(bus.freq_word), 32'(freq_exp_q.pop_front()));
      end
    end
  end

  task automatic flush();
    exp_q.delete();
    freq_exp_q.delete();
  endtask

  task automatic pulse_start(input bit push);
    if (push) begin
      flush();
      for (int s = 0; s < NSTEP; s++) begin
        wr_t e;
        logic [15:0] bin;
        bin    = 16'(3 + 2 * s);
        e.addr = 12'(s);
        e.re   = (bin == skip_bin) ? 16'd0 : bin;
        e.im   = (bin == skip_bin) ? 16'd0 : 16'(-int'(bin));
        exp_q.push_back(e);
        freq_exp_q.push_back(16'(10 + 5 * s));
      end
    end
    start_r = 1;
    @(negedge clk);
    start_r = 0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 800 && !bus.sweep_done; i++) @(negedge clk);
    check({tag, "_done"}, 32'(bus.sweep_done), 1);
  endtask

  task automatic wait_fft_valid(input string tag);
    for (int i = 0; i < 100 && !bus.fft_valid; i++) @(negedge clk);
    check({tag, "_fftv"}, 32'(bus.fft_valid), 1);
  endtask

  initial begin
    int base_wr, base_nf;
    n_vec = 0; n_err = 0; wr_cnt = 0; nf_cnt = 0;
    start_r = 0; abort_r = 0;
    skip_bin = 16'hFFFF; abort_bin = 16'hFFFF;
    rst_n = 0;
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // 1: clean sweep
    base_wr = wr_cnt; base_nf = nf_cnt;
    pulse_start(1);
    wait_done("t1");
    check("t1_err", 32'(bus.err), 0);
    check("t1_busy", 32'(bus.busy), 0);
    check("t1_wr_count", 32'(wr_cnt - base_wr), 4);
    check("t1_nf_count", 32'(nf_cnt - base_nf), 4);
    check("t1_sb_empty", 32'(exp_q.size() + freq_exp_q.size()), 0);

    // 2: bin 5 never appears -> step 1 times out and writes 0/0
    skip_bin = 16'd5;
    base_wr = wr_cnt;
    pulse_start(1);
    check("t2_done_clr", 32'(bus.sweep_done), 0);
    wait_done("t2");
    check("t2_err", 32'(bus.err), 1);
    check("t2_wr_count", 32'(wr_cnt - base_wr), 4);
    check("t2_sb_empty", 32'(exp_q.size()), 0);
    skip_bin = 16'hFFFF;

    // 4: second start mid-sweep is ignored; start clears err
    base_wr = wr_cnt;
    pulse_start(1);
    check("t4_err_clr", 32'(bus.err), 0);
    check("t4_busy", 32'(bus.busy), 1);
    repeat (30) @(negedge clk);
    pulse_start(0);
    wait_done("t4");
    check("t4_wr_count", 32'(wr_cnt - base_wr), 4);
    check("t4_sb_empty", 32'(exp_q.size() + freq_exp_q.size()), 0);

    // 3: abort during SETTLE of step 2
    base_wr = wr_cnt;
    pulse_start(1);
    for (int i = 0; i < 200 && (wr_cnt - base_wr) < 2; i++) @(negedge clk);
    check("t3_two_writes", 32'(wr_cnt - base_wr), 2);
    abort_r = 1;
    @(negedge clk);
    abort_r = 0;
    check("t3_busy", 32'(bus.busy), 0);
    check("t3_fftv", 32'(bus.fft_valid), 0);
    check("t3_done", 32'(bus.sweep_done), 0);
    check("t3_freq_hold", 32'(bus.freq_word), 20);
    flush();
    repeat (40) @(negedge clk);
    check("t3_no_more_wr", 32'(wr_cnt - base_wr), 2);
    base_wr = wr_cnt;
    pulse_start(1);
    wait_done("t3_restart");
    check("t3_restart_wr", 32'(wr_cnt - base_wr), 4);
    check("t3_sb_empty", 32'(exp_q.size() + freq_exp_q.size()), 0);

    // 5: abort in the same cycle as the bin match; then start+abort in IDLE
    abort_bin = 16'd3;
    base_wr = wr_cnt;
    pulse_start(1);
    wait_fft_valid("t5");
    repeat (20) @(negedge clk);
    abort_bin = 16'hFFFF;
    check("t5_no_wr", 32'(wr_cnt - base_wr), 0);
    check("t5_busy", 32'(bus.busy), 0);
    check("t5_fftv", 32'(bus.fft_valid), 0);
    flush();
    base_nf = nf_cnt;
    start_r = 1; abort_r = 1;
    @(negedge clk);
    start_r = 0; abort_r = 0;
    check("t5_idle_busy", 32'(bus.busy), 0);
    repeat (12) @(negedge clk);
    check("t5_idle_fftv", 32'(bus.fft_valid), 0);
    check("t5_idle_nf", 32'(nf_cnt - base_nf), 0);

    // 6: asynchronous reset mid-CAPTURE
    base_wr = wr_cnt;
    pulse_start(1);
    wait_fft_valid("t6");
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check_zero("t6_async");
    flush();
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("t6_busy", 32'(bus.busy), 0);
    check_zero("t6_after");
    check("t6_wr_count", 32'(wr_cnt - base_wr), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
